// File: rtl/envelope_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// dyn_pkg
//   Shared types and constants for the envelope sequencer voice path.
//   env_state_t : envelope FSM states
//   GAIN_W      : width of the eighths gain code (0..8)
//   GAIN_MAX    : full-scale gain code (8/8 = unity)
//   HOLD_STEPS  : number of step ticks spent at full gain
//   decay_dwell : step ticks a decay level g is held before dropping to g-1
// ----------------------------------------------------------------------------
package dyn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        HOLD,
        DECAY,
        DONE
    } env_state_t;

    localparam int unsigned GAIN_W     = 4;
    localparam logic [3:0]  GAIN_MAX   = 4'd8;
    localparam logic [3:0]  HOLD_STEPS = 4'd8;

    // Lower decay levels linger longer: level g lasts (8 - g) step ticks.
    function automatic logic [GAIN_W-1:0] decay_dwell(input logic [GAIN_W-1:0] g);
        return GAIN_MAX - g;
    endfunction

endpackage

// File: rtl/envelope_sequencer_if.sv
// ----------------------------------------------------------------------------
// envelope_sequencer_if
//   Bundles the note-player and codec sample-path signals of one voice.
//   note_start         : one-cycle pulse, start an envelope
//   note_duration[5:0] : note length code, sampled with an accepted start
//   beat               : one-cycle timebase tick
//   sample_in[15:0]    : signed codec sample
//   new_sample_ready   : sample_in valid this cycle
//   final_sample[15:0] : signed gain-scaled sample (registered)
//   final_sample_valid : one-cycle pulse one cycle after new_sample_ready
//   gain[3:0]          : current gain code 0..8
//   busy               : envelope in ATTACK/HOLD/DECAY
//   done_with_note     : one-cycle pulse at envelope end
//   master : note player / codec side; slave : envelope_sequencer
// ----------------------------------------------------------------------------
interface envelope_sequencer_if;

    logic        note_start;
    logic [5:0]  note_duration;
    logic        beat;
    logic [15:0] sample_in;
    logic        new_sample_ready;
    logic [15:0] final_sample;
    logic        final_sample_valid;
    logic [3:0]  gain;
    logic        busy;
    logic        done_with_note;

    modport master (
        output note_start, note_duration, beat, sample_in, new_sample_ready,
        input  final_sample, final_sample_valid, gain, busy, done_with_note
    );

    modport slave (
        input  note_start, note_duration, beat, sample_in, new_sample_ready,
        output final_sample, final_sample_valid, gain, busy, done_with_note
    );

endinterface

// File: rtl/envelope_sequencer_gain_scaler.sv
// ----------------------------------------------------------------------------
// gain_scaler
//   Combinational sample * gain / 8 with arithmetic (floor) rounding.
//   sample_i[15:0] : signed input sample
//   gain_i[3:0]    : gain code 0..8 in eighths
//   scaled_o[15:0] : signed (sample_i * gain_i) >>> 3
// ----------------------------------------------------------------------------
module gain_scaler (
    input  logic signed [15:0] sample_i,
    input  logic        [3:0]  gain_i,
    output logic signed [15:0] scaled_o
);

    logic signed [19:0] sample_ext;
    logic signed [19:0] gain_ext;
    logic signed [19:0] product;
    logic               unused_product_bits;

    assign sample_ext = 20'(sample_i);
    assign gain_ext   = signed'({16'd0, gain_i});
    assign product    = sample_ext * gain_ext;

    // With gain <= 8 the product shifted right by 3 always fits in 16 bits,
    // so the top bit is pure sign extension and can be dropped.
    assign scaled_o            = product[18:3];
    assign unused_product_bits = ^{product[19], product[2:0]};

endmodule

// File: rtl/envelope_sequencer.sv
// ----------------------------------------------------------------------------
// envelope_sequencer
//   Per-note amplitude envelope for one voice: attack -> hold -> decay -> done.
//   Gain rises 1..8 one step per step tick, holds at 8 for 8 step ticks, then
//   decays 7..1 with level g held (8-g) step ticks. A step tick is every
//   L = note_duration << STEP_SHIFT beats. The gain is applied to each new
//   sample and the scaled sample is registered.
//
//   Parameters : STEP_SHIFT - step length scaling, counter width 6+STEP_SHIFT
//   Ports      : clk   - system clock
//                reset - synchronous, active-high
//                bus   - envelope_sequencer_if.slave (note/sample signals)
//   Macro      : ENV_RETRIGGER_EN - when defined, note_start while busy or in
//                DONE restarts the envelope; otherwise starts are honoured
//                only in IDLE.
// ----------------------------------------------------------------------------
module envelope_sequencer
    import dyn_pkg::*;
#(
    parameter int unsigned STEP_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    envelope_sequencer_if.slave  bus
);

    localparam int unsigned     CW      = 6 + STEP_SHIFT;
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    env_state_t          state_q;
    logic [GAIN_W-1:0]   gain_q;
    logic                busy_q;
    logic                done_q;
    logic [15:0]         final_q;
    logic                valid_q;
    logic [CW-1:0]       step_cnt_q;
    logic [CW-1:0]       len_q;
    logic [GAIN_W-1:0]   dwell_q;

    logic [CW-1:0]       len_d;
    logic signed [15:0]  scaled_d;
    logic                running;
    logic                step_tick;
    logic                accept;

    gain_scaler u_gain_scaler (
        .sample_i (signed'(bus.sample_in)),
        .gain_i   (gain_q),
        .scaled_o (scaled_d)
    );

    assign len_d   = CW'(bus.note_duration) << STEP_SHIFT;
    assign running = (state_q == ATTACK) || (state_q == HOLD) || (state_q == DECAY);

    // len_q is never zero while running: a zero length goes straight to DONE.
    assign step_tick = bus.beat && running && (step_cnt_q == len_q - CNT_ONE);

`ifdef ENV_RETRIGGER_EN
    assign accept = bus.note_start;
`else
    assign accept = bus.note_start && (state_q == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gain_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            final_q    <= '0;
            valid_q    <= 1'b0;
            step_cnt_q <= '0;
            len_q      <= '0;
            dwell_q    <= '0;
        end else begin
            valid_q <= bus.new_sample_ready;
            if (bus.new_sample_ready) begin
                final_q <= scaled_d;
            end

            done_q <= 1'b0;

            // An accepted start takes priority over any beat in the same cycle,
            // so that beat is dropped rather than counted.
            if (accept) begin
                len_q      <= len_d;
                step_cnt_q <= '0;
                dwell_q    <= '0;
                if (len_d == '0) begin
                    state_q <= DONE;
                    gain_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ATTACK;
                    gain_q  <= GAIN_W'(1);
                    busy_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                    end

                    ATTACK, HOLD, DECAY: begin
                        if (bus.beat) begin
                            step_cnt_q <= step_tick ? '0 : step_cnt_q + CNT_ONE;
                        end
                        if (step_tick) begin
                            if (state_q == ATTACK) begin
                                if (gain_q == GAIN_MAX - 4'd1) begin
                                    state_q <= HOLD;
                                    gain_q  <= GAIN_MAX;
                                    dwell_q <= '0;
                                end else begin
                                    gain_q <= gain_q + 4'd1;
                                end
                            end else if (state_q == HOLD) begin
                                if (dwell_q == HOLD_STEPS - 4'd1) begin
                                    state_q <= DECAY;
                                    gain_q  <= GAIN_MAX - 4'd1;
                                    dwell_q <= '0;
                                end else begin
                                    dwell_q <= dwell_q + 4'd1;
                                end
                            end else begin
                                if (dwell_q == decay_dwell(gain_q) - 4'd1) begin
                                    dwell_q <= '0;
                                    if (gain_q == 4'd1) begin
                                        state_q <= DONE;
                                        gain_q  <= '0;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end else begin
                                        gain_q <= gain_q - 4'd1;
                                    end
                                end else begin
                                    dwell_q <= dwell_q + 4'd1;
                                end
                            end
                        end
                    end

                    DONE: begin
                        state_q <= IDLE;
                    end

                    default: begin
                        state_q <= IDLE;
                        gain_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.final_sample       = final_q;
    assign bus.final_sample_valid = valid_q;
    assign bus.gain               = gain_q;
    assign bus.busy               = busy_q;
    assign bus.done_with_note     = done_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// ----------------------------------------------------------------------------
// tb_envelope_sequencer
//   Self-checking bench for envelope_sequencer. A reference model tracks the
//   number of counted beats since the note started and derives the gain from
//   the step-tick count arithmetically; the scaled sample is computed with
//   integer arithmetic. Directed scenarios are followed by random traffic.
// ----------------------------------------------------------------------------
module tb_envelope_sequencer;

    localparam int unsigned SS = 0;
`ifdef ENV_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    envelope_sequencer_if bus ();

    envelope_sequencer #(.STEP_SHIFT(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: 0 idle, 1 running, 2 done
    int          m_st = 0;
    int          m_cnt = 0;
    int          m_L = 0;
    logic [3:0]  e_gain = '0;
    logic        e_busy = 1'b0;
    logic        e_done = 1'b0;
    logic        e_valid = 1'b0;
    logic [15:0] e_final = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gain after a given number of completed step ticks (43 ticks per note).
    function automatic logic [3:0] gain_of(input int ticks);
        int d;
        int g;
        if (ticks < 7) return 4'(ticks + 1);
        if (ticks < 15) return 4'd8;
        d = ticks - 15;
        g = 7;
        while (g > 1 && d >= 8 - g) begin
            d = d - (8 - g);
            g = g - 1;
        end
        return 4'(g);
    endfunction

    function automatic logic [15:0] scale_ref(input logic [15:0] s, input logic [3:0] g);
        int p;
        p = int'($signed(s)) * int'(g);
        p = p >>> 3;
        return p[15:0];
    endfunction

    task automatic model_start(input logic [5:0] dur);
        m_L   = int'(dur) << SS;
        m_cnt = 0;
        m_st  = (m_L == 0) ? 2 : 1;
    endtask

    task automatic model_edge();
        logic [3:0] gp;
        gp = e_gain;
        if (reset) begin
            m_st    = 0;
            m_cnt   = 0;
            e_final = '0;
            e_valid = 1'b0;
        end else begin
            e_valid = bus.new_sample_ready;
            if (bus.new_sample_ready) e_final = scale_ref(bus.sample_in, gp);
            case (m_st)
                0: if (bus.note_start) model_start(bus.note_duration);
                1: begin
                    if (bus.note_start && RETRIG) model_start(bus.note_duration);
                    else if (bus.beat) begin
                        m_cnt++;
                        if (m_cnt == 43 * m_L) m_st = 2;
                    end
                end
                default: begin
                    if (bus.note_start && RETRIG) model_start(bus.note_duration);
                    else m_st = 0;
                end
            endcase
        end
        e_busy = (m_st == 1);
        e_done = (m_st == 2);
        e_gain = (m_st == 1) ? gain_of(m_cnt / m_L) : 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("gain",  32'(bus.gain), 32'(e_gain));
        check_eq("busy",  32'(bus.busy), 32'(e_busy));
        check_eq("done",  32'(bus.done_with_note), 32'(e_done));
        check_eq("valid", 32'(bus.final_sample_valid), 32'(e_valid));
        check_eq("final", 32'(bus.final_sample), 32'(e_final));
        if (bus.done_with_note) done_seen++;
        reset                = 1'b0;
        bus.note_start       = 1'b0;
        bus.beat             = 1'b0;
        bus.new_sample_ready = 1'b0;
    endtask

    task automatic drive(input logic st, input logic [5:0] dur, input logic bt,
                         input logic rdy, input logic [15:0] smp);
        bus.note_start       = st;
        bus.note_duration    = dur;
        bus.beat             = bt;
        bus.new_sample_ready = rdy;
        bus.sample_in        = smp;
        tick();
    endtask

    // Beat every cycle until done_with_note, bounded.
    task automatic finish_note(input string tag);
        int n;
        n = 0;
        while (!bus.done_with_note && n < 600) begin
            drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
            n++;
        end
        check_eq(tag, 32'(bus.done_with_note), 32'd1);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        int beats;
        int d0;
        int n;
        logic [3:0] g_first;
        logic [3:0] gmax;

        reset                = 1'b1;
        bus.note_start       = 1'b0;
        bus.note_duration    = '0;
        bus.beat             = 1'b0;
        bus.sample_in        = '0;
        bus.new_sample_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_gain", 32'(bus.gain), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        // Full envelope, L=2, beat every cycle: 86 beats, one done pulse.
        d0 = done_seen;
        drive(1'b1, 6'd2, 1'b0, 1'b0, 16'h0);
        beats = 0;
        while (!bus.done_with_note && beats < 200) begin
            drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
            beats++;
        end
        check_eq("t1_beats", 32'(beats), 32'd86);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 16'h0);
        check_eq("t1_done_cnt", 32'(done_seen - d0), 32'd1);

        // Scaling at gains 1, 4 and 8 with L=1.
        drive(1'b1, 6'd1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 6'd0, 1'b0, 1'b1, 16'h8000);
        check_eq("t2_g1", 32'(bus.final_sample), 32'h0000_F000);
        for (int i = 0; i < 3; i++) drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        check_eq("t2_gain4", 32'(bus.gain), 32'd4);
        drive(1'b0, 6'd0, 1'b0, 1'b1, 16'h4000);
        check_eq("t2_g4", 32'(bus.final_sample), 32'h0000_2000);
        check_eq("t2_valid", 32'(bus.final_sample_valid), 32'd1);
        drive(1'b0, 6'd0, 1'b0, 1'b0, 16'h0);
        check_eq("t2_valid_drop", 32'(bus.final_sample_valid), 32'd0);
        check_eq("t2_hold", 32'(bus.final_sample), 32'h0000_2000);
        for (int i = 0; i < 4; i++) drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        check_eq("t2_gain8", 32'(bus.gain), 32'd8);
        drive(1'b0, 6'd0, 1'b0, 1'b1, 16'h7FFF);
        check_eq("t2_g8", 32'(bus.final_sample), 32'h0000_7FFF);
        finish_note("t2_end");

        // Zero duration: done within 2 cycles, gain never nonzero.
        d0 = done_seen;
        gmax = '0;
        drive(1'b1, 6'd0, 1'b0, 1'b0, 16'h0);
        if (bus.gain > gmax) gmax = bus.gain;
        drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        if (bus.gain > gmax) gmax = bus.gain;
        check_eq("t3_done", 32'(done_seen - d0), 32'd1);
        check_eq("t3_gain", 32'(gmax), 32'd0);

        // Reset during HOLD aborts with no done pulse.
        d0 = done_seen;
        drive(1'b1, 6'd1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        check_eq("t4_in_hold", 32'(bus.gain), 32'd8);
        reset = 1'b1;
        drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        check_eq("t4_gain", 32'(bus.gain), 32'd0);
        check_eq("t4_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
        check_eq("t4_no_done", 32'(done_seen - d0), 32'd0);

        // Start during DECAY at gain 3.
        d0 = done_seen;
        drive(1'b1, 6'd1, 1'b0, 1'b0, 16'h0);
        n = 0;
        while (!(bus.gain == 4'd3 && m_cnt >= 15) && n < 100) begin
            drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
            n++;
        end
        check_eq("t5_reach", 32'(bus.gain), 32'd3);
        drive(1'b1, 6'd1, 1'b0, 1'b0, 16'h0);
`ifdef ENV_RETRIGGER_EN
        check_eq("t5_retrig", 32'(bus.gain), 32'd1);
`else
        check_eq("t5_ignored", 32'(bus.gain), 32'd3);
`endif
        finish_note("t5_end");
        check_eq("t5_done_cnt", 32'(done_seen - d0), 32'd1);

        // Start with a coincident beat: first gain change L beats later.
        drive(1'b1, 6'd3, 1'b1, 1'b0, 16'h0);
        g_first = bus.gain;
        beats = 0;
        while (bus.gain == g_first && beats < 20) begin
            drive(1'b0, 6'd0, 1'b1, 1'b0, 16'h0);
            beats++;
        end
        check_eq("t6_first_step", 32'(beats), 32'd3);
        finish_note("t6_end");

        // Random traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 59) == 0, 6'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                  16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
